// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
//   Owns the three-slot obstacle (cactus) population for the scrolling
//   playfield. On each qualifying scroll step (tick=1, halt=0) every active
//   slot moves left by SPEED or retires at the left edge. A gap counter
//   paces spawns into the lowest free slot. Retirements are counted as the
//   pass score.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high; clears all slots and the score
//   tick         one-cycle scroll step pulse (once per frame)
//   halt         collision freeze, level-sensitive; blocks all updates
//   random       free-running rng value, sampled only on a spawning step
//   obs_active   bit i set = slot i valid
//   obs_type     slot i type in bits [2i+1:2i] (0..2)
//   obs_x        slot i x in bits [X_W*(i+1)-1 : X_W*i], 0 when inactive
//   pass_count   obstacles retired since reset, saturating at 16'hFFFF
//   spawn_pulse  one-cycle strobe in the cycle after a spawn commits
module obstacle_scheduler #(
  parameter int X_W      = 11,
  parameter int SPAWN_X  = 660,
  parameter int SPEED    = 2,
  parameter int INIT_GAP = 30,
  parameter int MIN_GAP  = 60,
  parameter int GAP_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             halt,
  input  logic [4:0]       random,
  output logic [2:0]       obs_active,
  output logic [5:0]       obs_type,
  output logic [3*X_W-1:0] obs_x,
  output logic [15:0]      pass_count,
  output logic             spawn_pulse
);

  localparam int NSLOT = 3;

  logic           active_reg [NSLOT];
  logic           active_next[NSLOT];
  logic [1:0]     type_reg   [NSLOT];
  logic [1:0]     type_next  [NSLOT];
  logic [X_W-1:0] x_reg      [NSLOT];
  logic [X_W-1:0] x_next     [NSLOT];

  logic [7:0]  gap_reg, gap_next;
  logic [15:0] pass_reg, pass_next;
  logic        pulse_reg;

  logic             step;
  logic [NSLOT-1:0] free_vec;
  logic [NSLOT-1:0] spawn_sel;
  logic             do_spawn;
  logic [1:0]       spawn_type;
  logic [7:0]       gap_reload;
  logic [1:0]       retire_cnt;
  logic [16:0]      pass_sum;

  assign step = tick & ~halt;

  // Freedom is judged on the state at the start of the step, so a slot
  // retiring on this step is not reused until the next one.
  always_comb begin
    free_vec = '0;
    for (int i = 0; i < NSLOT; i++) begin
      free_vec[i] = ~active_reg[i];
    end
  end

  // Isolate the lowest set bit: the lowest-index free slot.
  assign spawn_sel  = free_vec & (~free_vec + NSLOT'(1));
  assign do_spawn   = step && (gap_reg == 8'd0) && (|free_vec);
  assign spawn_type = (random[1:0] == 2'd3) ? 2'd0 : random[1:0];
  assign gap_reload = 8'(MIN_GAP + 32'(random[4:2]) * GAP_STEP);

  // Per-slot move / retire / spawn. Spawn only targets an inactive slot, so
  // it can never collide with a move or retire of the same slot.
  always_comb begin
    retire_cnt = 2'd0;
    for (int i = 0; i < NSLOT; i++) begin
      active_next[i] = active_reg[i];
      type_next[i]   = type_reg[i];
      x_next[i]      = x_reg[i];
      if (step) begin
        if (active_reg[i]) begin
          if (x_reg[i] < X_W'(SPEED)) begin
            active_next[i] = 1'b0;
            x_next[i]      = '0;
            type_next[i]   = 2'd0;
            retire_cnt     = retire_cnt + 2'd1;
          end else begin
            x_next[i] = x_reg[i] - X_W'(SPEED);
          end
        end else if (do_spawn && spawn_sel[i]) begin
          active_next[i] = 1'b1;
          x_next[i]      = X_W'(SPAWN_X);
          type_next[i]   = spawn_type;
        end
      end
    end
  end

  // With every slot full the counter parks at 0 and the spawn retries on
  // each step until a slot frees.
  always_comb begin
    gap_next = gap_reg;
    if (step) begin
      if (gap_reg != 8'd0) begin
        gap_next = gap_reg - 8'd1;
      end else if (do_spawn) begin
        gap_next = gap_reload;
      end
    end
  end

  assign pass_sum  = {1'b0, pass_reg} + 17'(retire_cnt);
  assign pass_next = pass_sum[16] ? 16'hFFFF : pass_sum[15:0];

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          active_reg[gi] <= 1'b0;
          type_reg[gi]   <= 2'd0;
          x_reg[gi]      <= '0;
        end else begin
          active_reg[gi] <= active_next[gi];
          type_reg[gi]   <= type_next[gi];
          x_reg[gi]      <= x_next[gi];
        end
      end

      assign obs_active[gi]          = active_reg[gi];
      assign obs_type[2*gi +: 2]     = type_reg[gi];
      assign obs_x[X_W*gi +: X_W]    = x_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_reg   <= 8'(INIT_GAP);
      pass_reg  <= 16'd0;
      pulse_reg <= 1'b0;
    end else begin
      gap_reg   <= gap_next;
      pass_reg  <= pass_next;
      // do_spawn already includes the step qualifier, so the strobe drops
      // on any non-qualifying cycle.
      pulse_reg <= do_spawn;
    end
  end

  assign pass_count  = pass_reg;
  assign spawn_pulse = pulse_reg;

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

  localparam int X_W = 11;

  logic             clk;
  logic             reset;
  logic             tick;
  logic             halt;
  logic [4:0]       random;
  logic [2:0]       obs_active;
  logic [5:0]       obs_type;
  logic [3*X_W-1:0] obs_x;
  logic [15:0]      pass_count;
  logic             spawn_pulse;

  int n_total;
  int n_pass;

  obstacle_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .halt       (halt),
    .random     (random),
    .obs_active (obs_active),
    .obs_type   (obs_type),
    .obs_x      (obs_x),
    .pass_count (pass_count),
    .spawn_pulse(spawn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;     // number of ticks applied in this step
    logic        h;     // halt during those ticks
    logic [4:0]  rnd;   // random during those ticks
    logic [2:0]  act;
    logic [5:0]  typ;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [10:0] x2;
    logic [15:0] pass;
    logic        pulse;
  } vec_t;

  vec_t vec[22];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One scroll step: tick high across exactly one rising edge; outputs are
  // sampled 1 time unit after that edge.
  task automatic do_tick(input logic h, input logic [4:0] r);
    @(negedge clk);
    tick   = 1'b1;
    halt   = h;
    random = r;
    @(posedge clk);
    #1;
    tick = 1'b0;
    halt = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [2:0] act, input logic [5:0] typ,
                           input logic [10:0] x0, input logic [10:0] x1, input logic [10:0] x2,
                           input logic [15:0] pass, input logic pulse);
    check({tag, ".active"}, 64'(obs_active), 64'(act));
    check({tag, ".type"},   64'(obs_type),   64'(typ));
    check({tag, ".x0"},     64'(obs_x[10:0]),  64'(x0));
    check({tag, ".x1"},     64'(obs_x[21:11]), 64'(x1));
    check({tag, ".x2"},     64'(obs_x[32:22]), 64'(x2));
    check({tag, ".pass"},   64'(pass_count), 64'(pass));
    check({tag, ".pulse"},  64'(spawn_pulse), 64'(pulse));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    tick    = 1'b0;
    halt    = 1'b0;
    random  = 5'd0;

    //           n    h     rnd        act     typ        x0      x1      x2      pass   pulse
    vec[0]  = '{29, 1'b0, 5'b00000, 3'b000, 6'b000000, 11'd0,   11'd0,   11'd0,   16'd0, 1'b0};
    vec[1]  = '{1,  1'b0, 5'b00000, 3'b000, 6'b000000, 11'd0,   11'd0,   11'd0,   16'd0, 1'b0};
    vec[2]  = '{1,  1'b0, 5'b10111, 3'b001, 6'b000000, 11'd660, 11'd0,   11'd0,   16'd0, 1'b1};
    vec[3]  = '{1,  1'b0, 5'b00000, 3'b001, 6'b000000, 11'd658, 11'd0,   11'd0,   16'd0, 1'b0};
    vec[4]  = '{98, 1'b0, 5'b00000, 3'b001, 6'b000000, 11'd462, 11'd0,   11'd0,   16'd0, 1'b0};
    vec[5]  = '{50, 1'b1, 5'b00000, 3'b001, 6'b000000, 11'd462, 11'd0,   11'd0,   16'd0, 1'b0};
    vec[6]  = '{1,  1'b0, 5'b00000, 3'b001, 6'b000000, 11'd460, 11'd0,   11'd0,   16'd0, 1'b0};
    vec[7]  = '{1,  1'b0, 5'b00010, 3'b011, 6'b001000, 11'd458, 11'd660, 11'd0,   16'd0, 1'b1};
    vec[8]  = '{60, 1'b0, 5'b00000, 3'b011, 6'b001000, 11'd338, 11'd540, 11'd0,   16'd0, 1'b0};
    vec[9]  = '{1,  1'b0, 5'b00101, 3'b111, 6'b011000, 11'd336, 11'd538, 11'd660, 16'd0, 1'b1};
    vec[10] = '{68, 1'b0, 5'b00000, 3'b111, 6'b011000, 11'd200, 11'd402, 11'd524, 16'd0, 1'b0};
    vec[11] = '{1,  1'b0, 5'b00000, 3'b111, 6'b011000, 11'd198, 11'd400, 11'd522, 16'd0, 1'b0};
    vec[12] = '{97, 1'b0, 5'b00000, 3'b111, 6'b011000, 11'd4,   11'd206, 11'd328, 16'd0, 1'b0};
    vec[13] = '{1,  1'b0, 5'b00000, 3'b111, 6'b011000, 11'd2,   11'd204, 11'd326, 16'd0, 1'b0};
    vec[14] = '{1,  1'b0, 5'b00000, 3'b111, 6'b011000, 11'd0,   11'd202, 11'd324, 16'd0, 1'b0};
    vec[15] = '{1,  1'b0, 5'b00000, 3'b110, 6'b011000, 11'd0,   11'd200, 11'd322, 16'd1, 1'b0};
    vec[16] = '{1,  1'b0, 5'b00010, 3'b111, 6'b011010, 11'd660, 11'd198, 11'd320, 16'd1, 1'b1};
    vec[17] = '{60, 1'b0, 5'b00000, 3'b111, 6'b011010, 11'd540, 11'd78,  11'd200, 16'd1, 1'b0};
    vec[18] = '{39, 1'b0, 5'b00000, 3'b111, 6'b011010, 11'd462, 11'd0,   11'd122, 16'd1, 1'b0};
    vec[19] = '{1,  1'b0, 5'b00000, 3'b101, 6'b010010, 11'd460, 11'd0,   11'd120, 16'd2, 1'b0};
    vec[20] = '{1,  1'b0, 5'b00001, 3'b111, 6'b010110, 11'd458, 11'd660, 11'd118, 16'd2, 1'b1};
    vec[21] = '{20, 1'b1, 5'b00011, 3'b111, 6'b010110, 11'd458, 11'd660, 11'd118, 16'd2, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 3'b000, 6'b0, 11'd0, 11'd0, 11'd0, 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 22; v++) begin
      for (int k = 0; k < vec[v].n; k++) begin
        do_tick(vec[v].h, vec[v].rnd);
      end
      $display("step %0d: %0d ticks halt=%0b rnd=%b -> active=%b type=%b x0=%0d x1=%0d x2=%0d pass=%0d pulse=%0b",
               v, vec[v].n, vec[v].h, vec[v].rnd, obs_active, obs_type,
               obs_x[10:0], obs_x[21:11], obs_x[32:22], pass_count, spawn_pulse);
      check_all($sformatf("vec%0d", v), vec[v].act, vec[v].typ, vec[v].x0, vec[v].x1,
                vec[v].x2, vec[v].pass, vec[v].pulse);
    end

    // Gap after the vec20 spawn is 60; 20 halted ticks must not have eaten
    // into it: 59 more steps stay quiet, the 60th leaves gap 0, the 61st
    // would spawn but all slots are full.
    for (int k = 0; k < 59; k++) do_tick(1'b0, 5'd0);
    check("gap_hold.pulse", 64'(spawn_pulse), 64'd0);
    check("gap_hold.x0", 64'(obs_x[10:0]), 64'd340);

    // Idle cycles (no tick) must hold state and keep the strobe low.
    repeat (4) @(posedge clk);
    #1;
    check("idle.x1", 64'(obs_x[21:11]), 64'd542);
    check("idle.pulse", 64'(spawn_pulse), 64'd0);

    // Asynchronous reset between edges clears outputs immediately.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset: active=%b type=%b x=%0h pass=%0d pulse=%0b",
             obs_active, obs_type, obs_x, pass_count, spawn_pulse);
    check("areset.active", 64'(obs_active), 64'd0);
    check("areset.type",   64'(obs_type),   64'd0);
    check("areset.x",      64'(obs_x),      64'd0);
    check("areset.pass",   64'(pass_count), 64'd0);
    check("areset.pulse",  64'(spawn_pulse), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // First spawn again after INIT_GAP+1 ticks.
    for (int k = 0; k < 30; k++) do_tick(1'b0, 5'd0);
    check("rerun30.active", 64'(obs_active), 64'd0);
    do_tick(1'b0, 5'b01001);
    $display("rerun tick31: active=%b type=%b x0=%0d pulse=%0b",
             obs_active, obs_type, obs_x[10:0], spawn_pulse);
    check("rerun31.active", 64'(obs_active), 64'd1);
    check("rerun31.type",   64'(obs_type),   64'd1);
    check("rerun31.x0",     64'(obs_x[10:0]), 64'd660);
    check("rerun31.pulse",  64'(spawn_pulse), 64'd1);
    // Strobe lasts exactly one cycle.
    @(posedge clk);
    #1;
    check("rerun31.pulse_drop", 64'(spawn_pulse), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
